// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and FSM encoding for the FC2 classifier stage.
package cnn_pkg;
   localparam int DATA_W   = 16;
   localparam int WEIGHT_W = 8;
   localparam int ACC_W    = 32;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      CMP,
      DONE
   } state_e;

   typedef logic signed [DATA_W-1:0]   act_t;
   typedef logic signed [WEIGHT_W-1:0] wgt_t;
   typedef logic signed [ACC_W-1:0]    acc_t;

   function automatic act_t relu(input act_t x);
      return x[DATA_W-1] ? '0 : x;
   endfunction
endpackage

// File: rtl/fc2_mac_unit.sv
// Serial FC2 MAC: one signed 16x8 product per enabled cycle.
// clr reloads the accumulator with init (bias or zero) instead.
module fc2_mac_unit
   import cnn_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic clr,
   input  logic en,
   input  acc_t init,
   input  act_t x,
   input  wgt_t w,
   output acc_t acc
);
   localparam int PROD_W = DATA_W + WEIGHT_W;

   logic signed [PROD_W-1:0] prod;
   acc_t acc_d, acc_q;

   always_comb begin
      prod  = PROD_W'(x) * PROD_W'(w);
      acc_d = acc_q;
      if (clr)
         acc_d = init;
      else if (en)
         acc_d = acc_q + ACC_W'(prod);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

   assign acc = acc_q;
endmodule

// File: rtl/fc2_argmax.sv
// FC2 classifier: int8 weight load, ReLU capture, serial MAC, argmax.
// Define FC2_BIAS_EN to append OUTPUT_NUM int8 biases to the load stream.
module fc2_argmax
   import cnn_pkg::*;
#(
   parameter int INPUT_NUM  = 16,
   parameter int OUTPUT_NUM = 10
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        weight_valid,
   input  logic [WEIGHT_W-1:0]         filter,
   input  logic                        i_valid,
   input  logic [INPUT_NUM*DATA_W-1:0] i_data,
   output logic                        weight_done,
   output logic                        o_busy,
   output logic                        o_valid,
   output logic [3:0]                  o_class,
   output acc_t                        o_max_logit
);
   localparam int IW = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
   localparam int OW = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1;
   localparam int RW = $clog2(OUTPUT_NUM + 1);
   localparam int CW = (IW > OW) ? IW : OW;
   localparam logic [IW-1:0] I_LAST  = IW'(INPUT_NUM - 1);
   localparam logic [OW-1:0] O_LAST  = OW'(OUTPUT_NUM - 1);
   localparam logic [CW-1:0] ROW_END = CW'(INPUT_NUM - 1);
`ifdef FC2_BIAS_EN
   localparam logic [RW-1:0] LD_LAST_ROW = RW'(OUTPUT_NUM);
   localparam logic [CW-1:0] LD_LAST_COL = CW'(OUTPUT_NUM - 1);
`else
   localparam logic [RW-1:0] LD_LAST_ROW = RW'(OUTPUT_NUM - 1);
   localparam logic [CW-1:0] LD_LAST_COL = CW'(INPUT_NUM - 1);
`endif

   state_e        state_q, state_d;
   logic          busy_q, busy_d;
   logic [IW-1:0] i_idx_q, i_idx_d;
   logic [OW-1:0] o_idx_q, o_idx_d;
   logic [OW-1:0] best_idx_q, best_idx_d;
   acc_t          best_val_q, best_val_d;
   logic          valid_q, valid_d;
   logic [3:0]    class_q, class_d;
   acc_t          max_q, max_d;
   logic [RW-1:0] ld_row_q, ld_row_d;
   logic [CW-1:0] ld_col_q, ld_col_d;
   logic          wdone_q, wdone_d;
   logic          ld_en, accept, mac_clr, mac_en;
   acc_t          mac_init, acc;
   act_t          x_q [INPUT_NUM];
   act_t          x_d [INPUT_NUM];
   wgt_t          w_q [OUTPUT_NUM][INPUT_NUM];
`ifdef FC2_BIAS_EN
   wgt_t          b_q [OUTPUT_NUM];
`endif

   always_comb begin
      ld_en    = weight_valid & ~wdone_q;
      ld_row_d = ld_row_q;
      ld_col_d = ld_col_q;
      wdone_d  = wdone_q;
      if (ld_en) begin
         if (ld_row_q == LD_LAST_ROW && ld_col_q == LD_LAST_COL) begin
            wdone_d = 1'b1;
         end else if (ld_col_q == ROW_END) begin
            ld_col_d = '0;
            ld_row_d = ld_row_q + RW'(1);
         end else begin
            ld_col_d = ld_col_q + CW'(1);
         end
      end
   end

   // Weight, bias and activation storage are deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (ld_en) begin
`ifdef FC2_BIAS_EN
         if (ld_row_q == LD_LAST_ROW)
            b_q[OW'(ld_col_q)] <= filter;
         else
            w_q[ld_row_q][IW'(ld_col_q)] <= filter;
`else
         w_q[ld_row_q][IW'(ld_col_q)] <= filter;
`endif
      end
      x_q <= x_d;
   end

   assign accept = i_valid & wdone_q & (state_q == IDLE);

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      i_idx_d    = i_idx_q;
      o_idx_d    = o_idx_q;
      best_idx_d = best_idx_q;
      best_val_d = best_val_q;
      valid_d    = 1'b0;
      class_d    = class_q;
      max_d      = max_q;
      mac_clr    = 1'b0;
      mac_en     = 1'b0;
      mac_init   = '0;
      x_d        = x_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = MAC;
               busy_d  = 1'b1;
               i_idx_d = '0;
               o_idx_d = '0;
               mac_clr = 1'b1;
`ifdef FC2_BIAS_EN
               mac_init = ACC_W'(b_q[0]);
`endif
               for (int j = 0; j < INPUT_NUM; j++)
                  x_d[j] = relu(i_data[j*DATA_W +: DATA_W]);
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (i_idx_q == I_LAST)
               state_d = CMP;
            else
               i_idx_d = i_idx_q + IW'(1);
         end
         CMP: begin
            // Strict compare keeps the lower index on ties.
            if (o_idx_q == '0 || acc > best_val_q) begin
               best_val_d = acc;
               best_idx_d = o_idx_q;
            end
            if (o_idx_q == O_LAST) begin
               state_d = DONE;
            end else begin
               state_d = MAC;
               o_idx_d = o_idx_q + OW'(1);
               i_idx_d = '0;
               mac_clr = 1'b1;
`ifdef FC2_BIAS_EN
               mac_init = ACC_W'(b_q[o_idx_d]);
`endif
            end
         end
         DONE: begin
            valid_d = 1'b1;
            class_d = 4'(best_idx_q);
            max_d   = best_val_q;
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         i_idx_q    <= '0;
         o_idx_q    <= '0;
         best_idx_q <= '0;
         best_val_q <= '0;
         valid_q    <= 1'b0;
         class_q    <= '0;
         max_q      <= '0;
         ld_row_q   <= '0;
         ld_col_q   <= '0;
         wdone_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         i_idx_q    <= i_idx_d;
         o_idx_q    <= o_idx_d;
         best_idx_q <= best_idx_d;
         best_val_q <= best_val_d;
         valid_q    <= valid_d;
         class_q    <= class_d;
         max_q      <= max_d;
         ld_row_q   <= ld_row_d;
         ld_col_q   <= ld_col_d;
         wdone_q    <= wdone_d;
      end
   end

   fc2_mac_unit u_mac (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .clr   (mac_clr),
      .en    (mac_en),
      .init  (mac_init),
      .x     (x_q[i_idx_q]),
      .w     (w_q[o_idx_q][i_idx_q]),
      .acc   (acc)
   );

   assign weight_done = wdone_q;
   assign o_busy      = busy_q;
   assign o_valid     = valid_q;
   assign o_class     = class_q;
   assign o_max_logit = max_q;
endmodule

// File: tb/tb_fc2_argmax.sv
// Scoreboard bench for fc2_argmax: a reference model predicts
// class/logit/latency per accepted vector; the monitor compares on o_valid.
module tb_fc2_argmax;
   localparam int IN  = 16;
   localparam int ON  = 10;
   localparam int LAT = 1 + ON * (IN + 1);

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b1;
   logic              weight_valid = 1'b0;
   logic              i_valid = 1'b0;
   logic [7:0]        filter = '0;
   logic [IN*16-1:0]  i_data = '0;
   logic              weight_done, o_busy, o_valid;
   logic [3:0]        o_class;
   logic signed [31:0] o_max_logit;

   typedef struct {
      int     cls;
      longint val;
      int     t0;
   } exp_t;

   exp_t sb_q[$];
   int   w_m [ON][IN];
   int   b_m [ON];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_ov = 0;

   fc2_argmax dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .weight_valid (weight_valid),
      .filter       (filter),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .weight_done  (weight_done),
      .o_busy       (o_busy),
      .o_valid      (o_valid),
      .o_class      (o_class),
      .o_max_logit  (o_max_logit)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic signed [63:0] got,
                      input logic signed [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   always @(posedge i_clk) begin
      #1;
      if (o_valid === 1'b1) begin
         n_ov++;
         chk("valid_expected", sb_q.size() != 0, 1);
         if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("class", o_class, e.cls);
            chk("max_logit", o_max_logit, e.val);
            chk("latency", cyc - e.t0, LAT);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      tick(2);
      i_rst = 1'b0;
      sb_q.delete();
      tick(1);
   endtask

   task automatic fill(input int v);
      for (int o = 0; o < ON; o++) begin
         b_m[o] = 0;
         for (int i = 0; i < IN; i++) w_m[o][i] = v;
      end
   endtask

   task automatic load();
      int total;
      total = IN * ON;
`ifdef FC2_BIAS_EN
      total += ON;
`endif
      for (int k = 0; k < total; k++) begin
         weight_valid = 1'b1;
         if (k < IN * ON)
            filter = 8'(w_m[k / IN][k % IN]);
         else
            filter = 8'(b_m[k - IN * ON]);
         if (k == total - 1) chk("wd_before_last", weight_done, 0);
         tick();
      end
      weight_valid = 1'b0;
      chk("wd_after_last", weight_done, 1);
   endtask

   task automatic drive_x(input int x);
      for (int j = 0; j < IN; j++) i_data[j*16 +: 16] = 16'(x);
   endtask

   task automatic push_exp(input int x, output exp_t e);
      longint acc, best;
      int     bi, xr;
      xr   = (x < 0) ? 0 : x;
      best = 0;
      bi   = 0;
      for (int o = 0; o < ON; o++) begin
         acc = 0;
`ifdef FC2_BIAS_EN
         acc = b_m[o];
`endif
         for (int i = 0; i < IN; i++) acc += longint'(xr) * w_m[o][i];
         if (o == 0 || acc > best) begin
            best = acc;
            bi   = o;
         end
      end
      e.cls = bi;
      e.val = best;
      e.t0  = cyc + 1;
      sb_q.push_back(e);
   endtask

   task automatic wait_valid();
      int waited;
      waited = 0;
      while (o_valid !== 1'b1 && waited < LAT + 20) begin
         tick();
         waited++;
      end
      chk("valid_seen", o_valid, 1);
   endtask

   task automatic infer(input int x);
      exp_t e;
      drive_x(x);
      push_exp(x, e);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      chk("busy_after_accept", o_busy, 1);
      wait_valid();
      chk("busy_at_done", o_busy, 0);
      tick(3);
      chk("class_hold", o_class, e.cls);
      chk("logit_hold", o_max_logit, e.val);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   n0;
      fill(0);
      tick(3);
      i_rst = 1'b0;
      tick(1);
      chk("rst_weight_done", weight_done, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_class", o_class, 0);
      chk("rst_logit", o_max_logit, 0);
      drive_x(100);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      tick(2);
      chk("early_valid_busy", o_busy, 0);

      fill(0);
      for (int i = 0; i < IN; i++) w_m[3][i] = 1;
      load();
      infer(100);

      do_reset();
      fill(1);
      load();
      infer(-5);

      do_reset();
      fill(1);
      for (int i = 0; i < IN; i++) begin
         w_m[2][i] = 2;
         w_m[7][i] = 2;
      end
      load();
      infer(10);

      do_reset();
      fill(0);
      for (int i = 0; i < IN; i++) w_m[0][i] = -128;
      load();
      infer(32767);

      n0 = n_ov;
      drive_x(50);
      push_exp(50, e);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      tick(49);
      drive_x(7);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      wait_valid();
      tick(LAT);
      chk("single_valid", n_ov - n0, 1);

      n0 = n_ov;
      drive_x(50);
      push_exp(50, e);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      tick(80);
      i_rst = 1'b1;
      #1;
      chk("midrst_busy", o_busy, 0);
      chk("midrst_wd", weight_done, 0);
      chk("midrst_class", o_class, 0);
      sb_q.delete();
      tick();
      i_rst = 1'b0;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      tick(LAT + 10);
      chk("no_valid_after_rst", n_ov - n0, 0);
      chk("busy_after_rst", o_busy, 0);

`ifdef FC2_BIAS_EN
      do_reset();
      fill(0);
      b_m[5] = 7;
      load();
      infer(3);
`endif

      tick(5);
      chk("sb_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
